// File: rtl/drive_sequencer_pkg.sv
// Shared types and constants for the line-follower drive sequencer.
package drive_sequencer_pkg;

    localparam logic [7:0] SPEED_FWD  = 8'd200;
    localparam logic [7:0] SPEED_TURN = 8'd120;
    localparam logic [7:0] SPEED_SLOW = 8'd60;

    // Debounced sensor patterns: bit 0 = left, bit 1 = right
    localparam logic [1:0] SNS_NONE  = 2'b00;
    localparam logic [1:0] SNS_LEFT  = 2'b01;
    localparam logic [1:0] SNS_RIGHT = 2'b10;
    localparam logic [1:0] SNS_BOTH  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FOLLOW  = 3'd1,
        ST_STEER_L = 3'd2,
        ST_STEER_R = 3'd3,
        ST_SEARCH  = 3'd4,
        ST_HALT    = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        FS_REST    = 2'b00,
        FS_LEFT    = 2'b01,
        FS_FORWARD = 2'b10,
        FS_RIGHT   = 2'b11
    } fstate_t;

    typedef enum logic {
        SIDE_L = 1'b0,
        SIDE_R = 1'b1
    } side_t;

    typedef struct packed {
        logic [7:0] speed_l;
        logic [7:0] speed_r;
        fstate_t    fstate;
        logic       line_lost;
    } drive_cmd_t;

    // Wheel command and reported state for a given FSM state and search side
    function automatic drive_cmd_t drive_cmd(input state_t st, input side_t side);
        drive_cmd_t c;
        c.speed_l   = 8'd0;
        c.speed_r   = 8'd0;
        c.fstate    = FS_REST;
        c.line_lost = 1'b0;
        case (st)
            ST_FOLLOW: begin
                c.speed_l = SPEED_FWD;
                c.speed_r = SPEED_FWD;
                c.fstate  = FS_FORWARD;
            end
            ST_STEER_L: begin
                c.speed_l = SPEED_SLOW;
                c.speed_r = SPEED_TURN;
                c.fstate  = FS_LEFT;
            end
            ST_STEER_R: begin
                c.speed_l = SPEED_TURN;
                c.speed_r = SPEED_SLOW;
                c.fstate  = FS_RIGHT;
            end
            ST_SEARCH: begin
                c.line_lost = 1'b1;
                if (side == SIDE_L) begin
                    c.speed_r = SPEED_TURN;
                    c.fstate  = FS_LEFT;
                end else begin
                    c.speed_l = SPEED_TURN;
                    c.fstate  = FS_RIGHT;
                end
            end
            ST_HALT: begin
                c.line_lost = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/drive_sequencer_if.sv
// Sensor/switch inputs and drive command outputs of the drive sequencer.
interface drive_sequencer_if;
    logic [1:0] sensor;
    logic [1:0] sw;
    logic [7:0] Wheel_Speed_L;
    logic [7:0] Wheel_Speed_R;
    logic [1:0] follower_state;
    logic       frame_tick;
    logic       line_lost;

    modport master (
        output sensor, sw,
        input  Wheel_Speed_L, Wheel_Speed_R, follower_state, frame_tick, line_lost
    );

    modport slave (
        input  sensor, sw,
        output Wheel_Speed_L, Wheel_Speed_R, follower_state, frame_tick, line_lost
    );
endinterface

// File: rtl/drive_sequencer_sensor_debounce.sv
// Two-flop synchroniser plus per-frame stability filter for the two line sensors.
module sensor_debounce #(
    parameter int unsigned DEBOUNCE_FRAMES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] raw,
    input  logic       frame_tick,
    output logic [1:0] deb
);
    localparam int unsigned CW = $clog2(DEBOUNCE_FRAMES + 1);

    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    cand;
    logic [CW-1:0] stable_cnt;

    // Synchronise every cycle; compare against the candidate once per frame
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1      <= 2'b00;
            sync2      <= 2'b00;
            cand       <= 2'b00;
            stable_cnt <= '0;
            deb        <= 2'b00;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (frame_tick) begin
                if (sync2 == cand) begin
                    if (stable_cnt != CW'(DEBOUNCE_FRAMES)) begin
                        stable_cnt <= stable_cnt + CW'(1);
                    end
                    if (stable_cnt >= CW'(DEBOUNCE_FRAMES - 1)) begin
                        deb <= cand;
                    end
                end else begin
                    cand       <= sync2;
                    stable_cnt <= CW'(1);
                    if (DEBOUNCE_FRAMES <= 1) begin
                        deb <= sync2;
                    end
                end
            end
        end
    end
endmodule

// File: rtl/drive_sequencer.sv
// Frame-based follow/steer/search/halt controller for the line follower.
module drive_sequencer
    import drive_sequencer_pkg::*;
#(
    parameter int unsigned FRAME_CYCLES    = 2_000_000,
    parameter int unsigned DEBOUNCE_FRAMES = 2,
    parameter int unsigned LOST_FRAMES     = 25,
    parameter int unsigned SEARCH_FRAMES   = 100
) (
    input logic              clk,
    input logic              rst,
    drive_sequencer_if.slave bus
);
    localparam int unsigned FW  = $clog2(FRAME_CYCLES);
    localparam int unsigned LW  = $clog2(LOST_FRAMES + 1);
    localparam int unsigned SCW = $clog2(SEARCH_FRAMES + 1);

    logic [FW-1:0]  frame_cnt;
    logic           frame_tick;
    logic [1:0]     sw_s1;
    logic [1:0]     sw_s2;
    logic [1:0]     deb;

    state_t         state, state_n;
    logic [LW-1:0]  lost_cnt, lost_n;
    logic [SCW-1:0] search_cnt, search_n;
    side_t          last_side, side_n;
    drive_cmd_t     cmd_q;

    sensor_debounce #(
        .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
    ) u_debounce (
        .clk        (clk),
        .rst        (rst),
        .raw        (bus.sensor),
        .frame_tick (frame_tick),
        .deb        (deb)
    );

    // Frame counter; tick is registered so it is high while count == FRAME_CYCLES-1
    always_ff @(posedge clk) begin
        if (!rst) begin
            frame_cnt  <= '0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= (frame_cnt == FW'(FRAME_CYCLES - 2));
            frame_cnt  <= (frame_cnt == FW'(FRAME_CYCLES - 1)) ? '0 : frame_cnt + FW'(1);
        end
    end

    // Switch synchroniser
    always_ff @(posedge clk) begin
        if (!rst) begin
            sw_s1 <= 2'b00;
            sw_s2 <= 2'b00;
        end else begin
            sw_s1 <= bus.sw;
            sw_s2 <= sw_s1;
        end
    end

    // State and counter registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            lost_cnt   <= '0;
            search_cnt <= '0;
            last_side  <= SIDE_L;
        end else begin
            state      <= state_n;
            lost_cnt   <= lost_n;
            search_cnt <= search_n;
            last_side  <= side_n;
        end
    end

    // Next-state logic; only frame ticks move the FSM
    always_comb begin
        state_n  = state;
        lost_n   = lost_cnt;
        search_n = search_cnt;
        side_n   = last_side;

        // Default search side follows the switch until a run starts
        if (state == ST_IDLE) begin
            side_n = side_t'(sw_s2[1]);
        end

        if (frame_tick) begin
            if (!sw_s2[0]) begin
                state_n = ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state_n  = ST_FOLLOW;
                        lost_n   = '0;
                        search_n = '0;
                    end
                    ST_FOLLOW, ST_STEER_L, ST_STEER_R, ST_SEARCH: begin
                        if (deb != SNS_NONE) begin
                            lost_n = '0;
                            case (deb)
                                SNS_BOTH: state_n = ST_FOLLOW;
                                SNS_LEFT: begin
                                    state_n = ST_STEER_L;
                                    side_n  = SIDE_L;
                                end
                                default: begin
                                    state_n = ST_STEER_R;
                                    side_n  = SIDE_R;
                                end
                            endcase
                        end else if (state == ST_SEARCH) begin
                            if (search_cnt != SCW'(SEARCH_FRAMES)) begin
                                search_n = search_cnt + SCW'(1);
                            end
                            if (search_cnt >= SCW'(SEARCH_FRAMES - 1)) begin
                                state_n = ST_HALT;
                            end
                        end else begin
                            if (lost_cnt != LW'(LOST_FRAMES)) begin
                                lost_n = lost_cnt + LW'(1);
                            end
                            if (lost_cnt >= LW'(LOST_FRAMES - 1)) begin
                                state_n  = ST_SEARCH;
                                search_n = '0;
                            end
                        end
                    end
                    ST_HALT: ;
                    default: state_n = ST_IDLE;
                endcase
            end
        end
    end

    // Output registers load alongside the state on each tick
    always_ff @(posedge clk) begin
        if (!rst) begin
            cmd_q <= '0;
        end else if (frame_tick) begin
            cmd_q <= drive_cmd(state_n, side_n);
        end
    end

    assign bus.Wheel_Speed_L  = cmd_q.speed_l;
    assign bus.Wheel_Speed_R  = cmd_q.speed_r;
    assign bus.follower_state = cmd_q.fstate;
    assign bus.line_lost      = cmd_q.line_lost;
    assign bus.frame_tick     = frame_tick;

endmodule

// File: tb/tb_drive_sequencer.sv
// Directed testbench for drive_sequencer with short simulation frames.
module tb_drive_sequencer;
    localparam int unsigned FRAME = 10;

    // {L speed, R speed, follower_state, line_lost}
    localparam logic [18:0] EXP_IDLE     = {8'd0,   8'd0,   2'b00, 1'b0};
    localparam logic [18:0] EXP_FOLLOW   = {8'd200, 8'd200, 2'b10, 1'b0};
    localparam logic [18:0] EXP_STEER_L  = {8'd60,  8'd120, 2'b01, 1'b0};
    localparam logic [18:0] EXP_STEER_R  = {8'd120, 8'd60,  2'b11, 1'b0};
    localparam logic [18:0] EXP_SEARCH_L = {8'd0,   8'd120, 2'b01, 1'b1};
    localparam logic [18:0] EXP_SEARCH_R = {8'd120, 8'd0,   2'b11, 1'b1};
    localparam logic [18:0] EXP_HALT     = {8'd0,   8'd0,   2'b00, 1'b1};

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    drive_sequencer_if bus();

    drive_sequencer #(
        .FRAME_CYCLES    (FRAME),
        .DEBOUNCE_FRAMES (2),
        .LOST_FRAMES     (3),
        .SEARCH_FRAMES   (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [18:0] outs();
        return {bus.Wheel_Speed_L, bus.Wheel_Speed_R, bus.follower_state, bus.line_lost};
    endfunction

    // Advance past n frame ticks, ending on the negedge after each tick edge
    task automatic wait_tick(input int n);
        int cyc;
        for (int i = 0; i < n; i++) begin
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
            end while (bus.frame_tick !== 1'b1 && cyc < 2 * FRAME);
            if (bus.frame_tick !== 1'b1) begin
                errors++;
                $display("FAIL tick_timeout: got no frame_tick in %0d cycles, required one", 2 * FRAME);
            end
            @(negedge clk);
        end
    endtask

    // Continuous monitor: tick period and output stability between ticks
    logic [18:0] prev_out  = '0;
    logic        prev_tick = 1'b0;
    logic        prev_rst  = 1'b0;
    logic        seen_tick = 1'b0;
    int          since     = 0;

    always @(negedge clk) begin
        if (rst && prev_rst) begin
            checks++;
            if (!prev_tick && outs() !== prev_out) begin
                errors++;
                $display("FAIL hold_off_tick: got %h required %h", outs(), prev_out);
            end
            since++;
            if (bus.frame_tick === 1'b1) begin
                if (seen_tick) begin
                    checks++;
                    if (since != FRAME) begin
                        errors++;
                        $display("FAIL tick_period: got %0d required %0d", since, FRAME);
                    end
                end
                seen_tick = 1'b1;
                since     = 0;
            end
        end else begin
            seen_tick = 1'b0;
            since     = 0;
        end
        prev_out  = outs();
        prev_tick = bus.frame_tick;
        prev_rst  = rst;
    end

    task automatic test_reset();
        rst        = 1'b0;
        bus.sensor = 2'b00;
        bus.sw     = 2'b00;
        repeat (3) @(negedge clk);
        checks++;
        if (outs() !== EXP_IDLE) begin
            errors++;
            $display("FAIL reset_outputs: got %h required %h", outs(), EXP_IDLE);
        end
        checks++;
        if (bus.frame_tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_tick: got %b required 0", bus.frame_tick);
        end
        rst    = 1'b1;
        bus.sw = 2'b01;
        bus.sensor = 2'b11;
    endtask

    task automatic test_follow();
        wait_tick(1);
        checks++;
        if (outs() !== EXP_FOLLOW) begin
            errors++;
            $display("FAIL follow_enter: got %h required %h", outs(), EXP_FOLLOW);
        end
        wait_tick(2);
        checks++;
        if (outs() !== EXP_FOLLOW) begin
            errors++;
            $display("FAIL follow_hold: got %h required %h", outs(), EXP_FOLLOW);
        end
    endtask

    task automatic test_glitch_steer_left();
        bus.sensor = 2'b01;
        wait_tick(1);
        bus.sensor = 2'b11;
        wait_tick(1);
        checks++;
        if (outs() !== EXP_FOLLOW) begin
            errors++;
            $display("FAIL glitch_ignored: got %h required %h", outs(), EXP_FOLLOW);
        end
        wait_tick(1);
        bus.sensor = 2'b01;
        wait_tick(2);
        checks++;
        if (outs() !== EXP_FOLLOW) begin
            errors++;
            $display("FAIL steer_l_debouncing: got %h required %h", outs(), EXP_FOLLOW);
        end
        wait_tick(1);
        checks++;
        if (outs() !== EXP_STEER_L) begin
            errors++;
            $display("FAIL steer_left: got %h required %h", outs(), EXP_STEER_L);
        end
    endtask

    task automatic test_search_left();
        bus.sensor = 2'b00;
        wait_tick(4);
        checks++;
        if (outs() !== EXP_STEER_L) begin
            errors++;
            $display("FAIL lost_below_limit: got %h required %h", outs(), EXP_STEER_L);
        end
        wait_tick(1);
        checks++;
        if (outs() !== EXP_SEARCH_L) begin
            errors++;
            $display("FAIL search_left: got %h required %h", outs(), EXP_SEARCH_L);
        end
        bus.sensor = 2'b10;
        wait_tick(2);
        checks++;
        if (outs() !== EXP_SEARCH_L) begin
            errors++;
            $display("FAIL search_debouncing: got %h required %h", outs(), EXP_SEARCH_L);
        end
        wait_tick(1);
        checks++;
        if (outs() !== EXP_STEER_R) begin
            errors++;
            $display("FAIL search_recover_r: got %h required %h", outs(), EXP_STEER_R);
        end
    endtask

    task automatic test_halt();
        bus.sensor = 2'b00;
        wait_tick(5);
        checks++;
        if (outs() !== EXP_SEARCH_R) begin
            errors++;
            $display("FAIL search_right: got %h required %h", outs(), EXP_SEARCH_R);
        end
        wait_tick(3);
        checks++;
        if (outs() !== EXP_SEARCH_R) begin
            errors++;
            $display("FAIL search_below_limit: got %h required %h", outs(), EXP_SEARCH_R);
        end
        wait_tick(1);
        checks++;
        if (outs() !== EXP_HALT) begin
            errors++;
            $display("FAIL halt_enter: got %h required %h", outs(), EXP_HALT);
        end
        bus.sensor = 2'b11;
        wait_tick(3);
        checks++;
        if (outs() !== EXP_HALT) begin
            errors++;
            $display("FAIL halt_ignores_line: got %h required %h", outs(), EXP_HALT);
        end
        bus.sw = 2'b00;
        wait_tick(1);
        checks++;
        if (outs() !== EXP_IDLE) begin
            errors++;
            $display("FAIL halt_to_idle: got %h required %h", outs(), EXP_IDLE);
        end
        bus.sw = 2'b01;
        wait_tick(1);
        checks++;
        if (outs() !== EXP_FOLLOW) begin
            errors++;
            $display("FAIL reenable_follow: got %h required %h", outs(), EXP_FOLLOW);
        end
    endtask

    task automatic test_run_off();
        bus.sensor = 2'b10;
        wait_tick(3);
        checks++;
        if (outs() !== EXP_STEER_R) begin
            errors++;
            $display("FAIL steer_right: got %h required %h", outs(), EXP_STEER_R);
        end
        repeat (3) @(negedge clk);
        bus.sw = 2'b00;
        repeat (2) @(negedge clk);
        checks++;
        if (outs() !== EXP_STEER_R) begin
            errors++;
            $display("FAIL hold_mid_frame: got %h required %h", outs(), EXP_STEER_R);
        end
        wait_tick(1);
        checks++;
        if (outs() !== EXP_IDLE) begin
            errors++;
            $display("FAIL run_off_idle: got %h required %h", outs(), EXP_IDLE);
        end
        bus.sw = 2'b01;
        wait_tick(1);
        checks++;
        if (outs() !== EXP_FOLLOW) begin
            errors++;
            $display("FAIL run_on_follow: got %h required %h", outs(), EXP_FOLLOW);
        end
        wait_tick(1);
        checks++;
        if (outs() !== EXP_STEER_R) begin
            errors++;
            $display("FAIL run_on_steer: got %h required %h", outs(), EXP_STEER_R);
        end
    endtask

    task automatic test_reset_midframe();
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({outs(), bus.frame_tick} !== {EXP_IDLE, 1'b0}) begin
            errors++;
            $display("FAIL reset_midframe: got %h required %h", {outs(), bus.frame_tick}, {EXP_IDLE, 1'b0});
        end
        rst = 1'b1;
        wait_tick(1);
        checks++;
        if (outs() !== EXP_FOLLOW) begin
            errors++;
            $display("FAIL post_reset_follow: got %h required %h", outs(), EXP_FOLLOW);
        end
    endtask

    initial begin
        test_reset();
        test_follow();
        test_glitch_steer_left();
        test_search_left();
        test_halt();
        test_run_off();
        test_reset_midframe();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, required finish before time limit");
        $fatal(1);
    end

endmodule
